// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module  : parking_pkg
// Brief   : Shared types and constants for the parking entry arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package parking_pkg;

    localparam int CODE_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        BLOCKED = 2'd2
    } arb_state_t;

    typedef enum logic {
        LANE_A = 1'b0,
        LANE_B = 1'b1
    } lane_t;

endpackage
`default_nettype wire

// File: rtl/parking_occupancy_counter.sv
`default_nettype none
// ============================================================================
// Module  : parking_occupancy_counter
// Brief   : Saturating up/down lot occupancy counter with full flag.
// Revision: 1.0 - initial release
// ============================================================================
module parking_occupancy_counter #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam logic [CNT_W-1:0] C_CAP = CNT_W'(CAPACITY);

    logic [CNT_W-1:0] r_count;

    // Simultaneous entry and exit cancel out, even at either limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && !dec && (r_count < C_CAP)) begin
            r_count <= r_count + 1'b1;
        end else if (dec && !inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign full  = (r_count == C_CAP);

endmodule
`default_nettype wire

// File: rtl/parking_entry_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : parking_entry_arbiter
// Brief   : Two-lane entry arbiter in front of a single gate controller,
//           with occupancy tracking. Optional session timeout is enabled
//           by defining PARKING_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module parking_entry_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY       = 8,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arrival_a,
    input  logic              arrival_b,
    input  logic [CODE_W-1:0] code_a,
    input  logic [CODE_W-1:0] code_b,
    input  logic              exit_pulse,
    input  logic              gate_close,
    input  logic              gate_blocked,
    output logic              vehicle_arrival,
    output logic [CODE_W-1:0] code,
    output logic              grant_a,
    output logic              grant_b,
    output logic              lane_blocked,
`ifdef PARKING_ARB_TIMEOUT_EN
    output logic              timeout,
`endif
    output logic [CNT_W-1:0]  occupancy,
    output logic              lot_full
);

    localparam logic [1:0] C_ST_IDLE    = IDLE;
    localparam logic [1:0] C_ST_SERVE   = SERVE;
    localparam logic [1:0] C_ST_BLOCKED = BLOCKED;

    logic [1:0] r_state;
    logic       r_grant_a;
    logic       r_grant_b;
    lane_t      r_prio;
    logic       w_gr_arrival;
    logic       w_inc;
    logic       w_full;

`ifdef PARKING_ARB_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [C_TMO_W-1:0] r_tmo_cnt;
    logic               r_timeout;
    assign timeout = r_timeout;
`endif

    assign w_gr_arrival = r_grant_a ? arrival_a : arrival_b;
    assign w_inc        = (r_state == C_ST_SERVE) && gate_close;

    // Grants are zero in IDLE, so the mux naturally outputs zero there.
    assign vehicle_arrival = (r_grant_a & arrival_a) | (r_grant_b & arrival_b);
    assign code            = r_grant_a ? code_a : (r_grant_b ? code_b : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= C_ST_IDLE;
            r_grant_a <= 1'b0;
            r_grant_b <= 1'b0;
            r_prio    <= LANE_A;
`ifdef PARKING_ARB_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef PARKING_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                C_ST_IDLE: begin
                    if (!w_full && (arrival_a || arrival_b)) begin
                        if (arrival_a && arrival_b) begin
                            r_grant_a <= (r_prio == LANE_A);
                            r_grant_b <= (r_prio == LANE_B);
                        end else begin
                            r_grant_a <= arrival_a;
                            r_grant_b <= arrival_b;
                        end
                        r_state <= C_ST_SERVE;
`ifdef PARKING_ARB_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                C_ST_SERVE: begin
                    if (gate_close || (!gate_blocked && !w_gr_arrival)) begin
                        r_grant_a <= 1'b0;
                        r_grant_b <= 1'b0;
                        r_prio    <= (r_prio == LANE_A) ? LANE_B : LANE_A;
                        r_state   <= C_ST_IDLE;
                    end else if (gate_blocked) begin
                        r_state <= C_ST_BLOCKED;
                    end
`ifdef PARKING_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == C_TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_grant_a <= 1'b0;
                        r_grant_b <= 1'b0;
                        r_prio    <= (r_prio == LANE_A) ? LANE_B : LANE_A;
                        r_state   <= C_ST_IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                C_ST_BLOCKED: begin
                    // Grant stays put; only the gate clearing ends the block.
                    if (!gate_blocked) begin
                        r_state <= C_ST_SERVE;
`ifdef PARKING_ARB_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                default: begin
                    r_state   <= C_ST_IDLE;
                    r_grant_a <= 1'b0;
                    r_grant_b <= 1'b0;
                end
            endcase
        end
    end

    assign grant_a      = r_grant_a;
    assign grant_b      = r_grant_b;
    assign lane_blocked = (r_state == C_ST_BLOCKED);
    assign lot_full     = w_full;

    parking_occupancy_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc),
        .dec   (exit_pulse),
        .count (occupancy),
        .full  (w_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_parking_entry_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_parking_entry_arbiter
// Brief   : Directed self-checking bench for parking_entry_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_parking_entry_arbiter;
    import parking_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              arrival_a, arrival_b;
    logic [CODE_W-1:0] code_a, code_b;
    logic              exit_pulse, gate_close, gate_blocked;
    logic              vehicle_arrival;
    logic [CODE_W-1:0] code;
    logic              grant_a, grant_b, lane_blocked;
    logic [3:0]        occupancy;
    logic              lot_full;
`ifdef PARKING_ARB_TIMEOUT_EN
    logic              timeout;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    parking_entry_arbiter #(
        .CAPACITY       (8),
        .CNT_W          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .arrival_a       (arrival_a),
        .arrival_b       (arrival_b),
        .code_a          (code_a),
        .code_b          (code_b),
        .exit_pulse      (exit_pulse),
        .gate_close      (gate_close),
        .gate_blocked    (gate_blocked),
        .vehicle_arrival (vehicle_arrival),
        .code            (code),
        .grant_a         (grant_a),
        .grant_b         (grant_b),
        .lane_blocked    (lane_blocked),
`ifdef PARKING_ARB_TIMEOUT_EN
        .timeout         (timeout),
`endif
        .occupancy       (occupancy),
        .lot_full        (lot_full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arrival_a = 0; arrival_b = 0; code_a = '0; code_b = '0;
        exit_pulse = 0; gate_close = 0; gate_blocked = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic enter_a();
        arrival_a = 1; tick();
        gate_close = 1; tick();
        gate_close = 0; arrival_a = 0; tick();
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1; #1;
        total++; if ({grant_a, grant_b, vehicle_arrival, lane_blocked, lot_full} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {grant_a, grant_b, vehicle_arrival, lane_blocked, lot_full}); end
        total++; if (code !== 16'h0) begin bad++; $display("FAIL reset_code got=%h exp=0000", code); end
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        rst = 0;
    endtask

    task automatic test_single();
        do_reset();
        arrival_a = 1; code_a = 16'h1234; code_b = 16'hBEEF; #1;
        total++; if (vehicle_arrival !== 1'b0 || code !== 16'h0) begin
            bad++; $display("FAIL idle_mux got=%b/%h exp=0/0000", vehicle_arrival, code); end
        tick();
        total++; if ({grant_a, grant_b} !== 2'b10) begin bad++; $display("FAIL single_grant got=%b exp=10", {grant_a, grant_b}); end
        total++; if (vehicle_arrival !== 1'b1 || code !== 16'h1234) begin
            bad++; $display("FAIL single_mux got=%b/%h exp=1/1234", vehicle_arrival, code); end
        code_a = 16'h5678; #1;
        total++; if (code !== 16'h5678) begin bad++; $display("FAIL comb_code got=%h exp=5678", code); end
        gate_close = 1; tick(); gate_close = 0; arrival_a = 0;
        total++; if (occupancy !== 4'd1 || grant_a !== 1'b0) begin
            bad++; $display("FAIL single_close got=%0d/%b exp=1/0", occupancy, grant_a); end
    endtask

    task automatic test_priority();
        do_reset();
        arrival_a = 1; arrival_b = 1; code_a = 16'hAAAA; code_b = 16'hBBBB;
        tick();
        total++; if ({grant_a, grant_b} !== 2'b10 || code !== 16'hAAAA) begin
            bad++; $display("FAIL prio_first got=%b/%h exp=10/aaaa", {grant_a, grant_b}, code); end
        gate_close = 1; tick(); gate_close = 0;
        total++; if ({grant_a, grant_b} !== 2'b00 || occupancy !== 4'd1) begin
            bad++; $display("FAIL prio_idle got=%b/%0d exp=00/1", {grant_a, grant_b}, occupancy); end
        tick();
        total++; if ({grant_a, grant_b} !== 2'b01 || code !== 16'hBBBB) begin
            bad++; $display("FAIL prio_second got=%b/%h exp=01/bbbb", {grant_a, grant_b}, code); end
        gate_close = 1; tick(); gate_close = 0; arrival_a = 0; arrival_b = 0;
        total++; if (occupancy !== 4'd2) begin bad++; $display("FAIL prio_occ got=%0d exp=2", occupancy); end
    endtask

    task automatic test_abandon();
        do_reset();
        arrival_a = 1; tick();
        arrival_a = 0; tick();
        total++; if (grant_a !== 1'b0 || occupancy !== 4'd0) begin
            bad++; $display("FAIL abandon got=%b/%0d exp=0/0", grant_a, occupancy); end
        arrival_a = 1; arrival_b = 1; tick();
        total++; if ({grant_a, grant_b} !== 2'b01) begin
            bad++; $display("FAIL abandon_prio got=%b exp=01", {grant_a, grant_b}); end
        arrival_a = 0; arrival_b = 0; tick();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) enter_a();
        total++; if (occupancy !== 4'd8 || lot_full !== 1'b1) begin
            bad++; $display("FAIL full_count got=%0d/%b exp=8/1", occupancy, lot_full); end
        arrival_b = 1; tick(); tick();
        total++; if (grant_b !== 1'b0) begin bad++; $display("FAIL full_nogrant got=%b exp=0", grant_b); end
        exit_pulse = 1; tick(); exit_pulse = 0;
        total++; if (occupancy !== 4'd7 || lot_full !== 1'b0 || grant_b !== 1'b0) begin
            bad++; $display("FAIL full_exit got=%0d/%b/%b exp=7/0/0", occupancy, lot_full, grant_b); end
        tick();
        total++; if (grant_b !== 1'b1) begin bad++; $display("FAIL full_regrant got=%b exp=1", grant_b); end
        arrival_b = 0; tick();
    endtask

    task automatic test_blocked();
        do_reset();
        arrival_b = 1; code_b = 16'h0B0B; tick();
        gate_blocked = 1; tick();
        total++; if (lane_blocked !== 1'b1 || grant_b !== 1'b1) begin
            bad++; $display("FAIL blk_enter got=%b/%b exp=1/1", lane_blocked, grant_b); end
        arrival_b = 0; tick(); tick();
        total++; if (lane_blocked !== 1'b1 || grant_b !== 1'b1 || vehicle_arrival !== 1'b0) begin
            bad++; $display("FAIL blk_hold got=%b/%b/%b exp=1/1/0", lane_blocked, grant_b, vehicle_arrival); end
        code_b = 16'h0C0C; #1;
        total++; if (code !== 16'h0C0C) begin bad++; $display("FAIL blk_code got=%h exp=0c0c", code); end
        arrival_b = 1; gate_blocked = 0; tick();
        total++; if (lane_blocked !== 1'b0 || grant_b !== 1'b1) begin
            bad++; $display("FAIL blk_release got=%b/%b exp=0/1", lane_blocked, grant_b); end
        gate_close = 1; tick(); gate_close = 0; arrival_b = 0;
        total++; if (occupancy !== 4'd1 || grant_b !== 1'b0) begin
            bad++; $display("FAIL blk_close got=%0d/%b exp=1/0", occupancy, grant_b); end
        gate_close = 1; gate_blocked = 1; tick(); gate_close = 0; gate_blocked = 0; tick();
        total++; if (occupancy !== 4'd1 || lane_blocked !== 1'b0 || grant_b !== 1'b0) begin
            bad++; $display("FAIL stray_gate got=%0d/%b/%b exp=1/0/0", occupancy, lane_blocked, grant_b); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 3; i++) enter_a();
        arrival_a = 1; tick();
        gate_close = 1; exit_pulse = 1; tick(); gate_close = 0; exit_pulse = 0; arrival_a = 0;
        total++; if (occupancy !== 4'd3) begin bad++; $display("FAIL inc_dec got=%0d exp=3", occupancy); end
        do_reset();
        exit_pulse = 1; tick(); exit_pulse = 0;
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL dec_zero got=%0d exp=0", occupancy); end
        arrival_a = 1; tick();
        rst = 1; #1;
        total++; if (grant_a !== 1'b0 || vehicle_arrival !== 1'b0) begin
            bad++; $display("FAIL async_rst got=%b/%b exp=0/0", grant_a, vehicle_arrival); end
        rst = 0; arrival_a = 0; tick();
    endtask

`ifdef PARKING_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        arrival_a = 1; tick();
        for (int i = 0; i < 15; i++) tick();
        total++; if (timeout !== 1'b0 || grant_a !== 1'b1) begin
            bad++; $display("FAIL tmo_early got=%b/%b exp=0/1", timeout, grant_a); end
        tick();
        total++; if (timeout !== 1'b1 || grant_a !== 1'b0 || occupancy !== 4'd0) begin
            bad++; $display("FAIL tmo_fire got=%b/%b/%0d exp=1/0/0", timeout, grant_a, occupancy); end
        arrival_b = 1; tick();
        total++; if (timeout !== 1'b0 || {grant_a, grant_b} !== 2'b01) begin
            bad++; $display("FAIL tmo_prio got=%b/%b exp=0/01", timeout, {grant_a, grant_b}); end
        arrival_a = 0; arrival_b = 0; tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_abandon();
        test_full();
        test_blocked();
        test_saturate();
`ifdef PARKING_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
